// File: rtl/mash_ddsm_gen.sv
// Wide-accumulator MASH 1-1-..-1 delta-sigma modulator for a fractional-N divider.
// Order can be selected at runtime; the block has a config handshake, phase nudge, LFSR dither and warm-up sequencing.
module mash_ddsm_gen #(
   parameter int ACC_W     = 24,
   parameter int ORDER_MAX = 4,
   parameter int INT_W     = 8,
   parameter int FRAC_W    = ORDER_MAX + 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic                     i_cfg_we,
   input  logic [ACC_W-1:0]         i_cfg_frac,
   input  logic [1:0]               i_cfg_order,
   input  logic [INT_W-1:0]         i_int,
   input  logic                     i_phase_we,
   input  logic [ACC_W-1:0]         i_phase,
   input  logic                     i_dither_en,
   input  logic [15:0]              i_seed,
   output logic                     o_cfg_ack,
   output logic                     o_valid,
   output logic signed [FRAC_W-1:0] o_frac,
   output logic [INT_W-1:0]         o_div
);

   localparam int WCNT_W = $clog2(ORDER_MAX + 1);

   typedef enum logic [1:0] {IDLE, CLEAR, WARM, RUN} state_t;

   state_t                  state, state_nxt;
   logic [WCNT_W-1:0]       warm_cnt;
   logic [ACC_W-1:0]        frac_reg;
   logic [ORDER_MAX-1:0]    stage_mask;
   logic [ORDER_MAX-1:0]    mask_new;
   logic                    order_change;
   logic                    active;
   logic [ACC_W-1:0]        acc [ORDER_MAX];
   logic [ACC_W-1:0]        acc_nxt [ORDER_MAX];
   logic [ORDER_MAX-1:0]    carry_nxt;
   logic [ORDER_MAX-1:0]    carry_hist [ORDER_MAX];
   logic [15:0]             lfsr;
   logic signed [FRAC_W-1:0] nc_sum;

   function automatic int binom(input int n, input int r);
      int v;
      v = 1;
      for (int i = 0; i < r; i++) v = v * (n - i) / (i + 1);
      return v;
   endfunction

   assign active = (state == WARM) || (state == RUN);

   // Selected order is kept as a thermometer mask of enabled stages; larger requests clamp to ORDER_MAX.
   always_comb begin
      int ord_idx;
      ord_idx  = int'(i_cfg_order);
      mask_new = '0;
      if (ord_idx > ORDER_MAX - 1) ord_idx = ORDER_MAX - 1;
      for (int k = 0; k < ORDER_MAX; k++) mask_new[k] = (k <= ord_idx);
      order_change = i_cfg_we && (mask_new != stage_mask) && active;
   end

   always_comb begin
      state_nxt = state;
      o_valid   = (state == RUN);
      case (state)
         IDLE:  if (i_en) state_nxt = CLEAR;
         CLEAR: state_nxt = WARM;
         WARM:  begin
            if (order_change) state_nxt = CLEAR;
            else if (warm_cnt == WCNT_W'(ORDER_MAX)) state_nxt = RUN;
         end
         RUN:   if (order_change) state_nxt = CLEAR;
         default: state_nxt = IDLE;
      endcase
      if (!i_en) state_nxt = IDLE;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         warm_cnt <= '0;
      end else begin
         state    <= state_nxt;
         warm_cnt <= (state == WARM) ? warm_cnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         frac_reg   <= '0;
         stage_mask <= ORDER_MAX'(1);
      end else if (i_cfg_we) begin
         frac_reg   <= i_cfg_frac;
         stage_mask <= mask_new;
      end
   end

   // Stage 1 takes F plus dither and phase; a double overflow still reports a single carry.
   always_comb begin
      logic [ACC_W+1:0] sum1;
      logic [ACC_W:0]   sumk;
      logic [ACC_W-1:0] phase_add;
      logic             dith;
      dith      = i_dither_en & lfsr[0];
      phase_add = (i_phase_we && state == RUN) ? i_phase : '0;
      sum1      = {2'b00, acc[0]} + {2'b00, frac_reg} + {2'b00, phase_add}
                + {{(ACC_W+1){1'b0}}, dith};
      sumk      = '0;
      carry_nxt = '0;
      acc_nxt[0]   = sum1[ACC_W-1:0];
      carry_nxt[0] = (|sum1[ACC_W+1:ACC_W]) & stage_mask[0];
      for (int k = 1; k < ORDER_MAX; k++) begin
         sumk         = {1'b0, acc[k]} + {1'b0, acc[k-1]};
         acc_nxt[k]   = sumk[ACC_W-1:0];
         carry_nxt[k] = sumk[ACC_W] & stage_mask[k];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < ORDER_MAX; k++) begin
            acc[k]        <= '0;
            carry_hist[k] <= '0;
         end
         lfsr <= 16'hACE1;
      end else if (active) begin
         for (int k = 0; k < ORDER_MAX; k++) acc[k] <= acc_nxt[k];
         carry_hist[0] <= carry_nxt;
         for (int d = 1; d < ORDER_MAX; d++) carry_hist[d] <= carry_hist[d-1];
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end else begin
         for (int k = 0; k < ORDER_MAX; k++) begin
            acc[k]        <= '0;
            carry_hist[k] <= '0;
         end
         if (state == CLEAR) lfsr <= (i_seed == 16'h0000) ? 16'hACE1 : i_seed;
      end
   end

   // Stage k is differentiated k-1 times and delayed so every stage lines up with the deepest pipeline.
   always_comb begin
      int y_acc;
      y_acc = 0;
      for (int k = 0; k < ORDER_MAX; k++) begin
         for (int j = 0; j <= k; j++) begin
            if (carry_hist[ORDER_MAX-1-k+j][k]) begin
               if (j % 2 == 1) y_acc = y_acc - binom(k, j);
               else            y_acc = y_acc + binom(k, j);
            end
         end
      end
      nc_sum = y_acc[FRAC_W-1:0];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_frac    <= '0;
         o_div     <= '0;
         o_cfg_ack <= 1'b0;
      end else begin
         o_cfg_ack <= i_cfg_we;
         if (active) begin
            o_frac <= nc_sum;
            o_div  <= i_int + {{(INT_W-FRAC_W){nc_sum[FRAC_W-1]}}, nc_sum};
         end else begin
            o_frac <= '0;
            o_div  <= i_int;
         end
      end
   end

endmodule

// File: tb/tb_mash_ddsm_gen.sv
// Self-checking bench for mash_ddsm_gen: directed scenarios plus randomized runs
// compared every cycle against an arithmetic model of the modulator.
module tb_mash_ddsm_gen;

   localparam int ACC_W     = 24;
   localparam int ORDER_MAX = 4;
   localparam int INT_W     = 8;
   localparam int FRAC_W    = 5;
   localparam longint MOD   = longint'(1) << ACC_W;

   logic                     i_clk = 1'b0;
   logic                     i_rst;
   logic                     i_en;
   logic                     i_cfg_we;
   logic [ACC_W-1:0]         i_cfg_frac;
   logic [1:0]               i_cfg_order;
   logic [INT_W-1:0]         i_int;
   logic                     i_phase_we;
   logic [ACC_W-1:0]         i_phase;
   logic                     i_dither_en;
   logic [15:0]              i_seed;
   logic                     o_cfg_ack;
   logic                     o_valid;
   logic signed [FRAC_W-1:0] o_frac;
   logic [INT_W-1:0]         o_div;

   mash_ddsm_gen #(
      .ACC_W(ACC_W), .ORDER_MAX(ORDER_MAX), .INT_W(INT_W), .FRAC_W(FRAC_W)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_cfg_we(i_cfg_we),
      .i_cfg_frac(i_cfg_frac), .i_cfg_order(i_cfg_order), .i_int(i_int),
      .i_phase_we(i_phase_we), .i_phase(i_phase), .i_dither_en(i_dither_en),
      .i_seed(i_seed), .o_cfg_ack(o_cfg_ack), .o_valid(o_valid),
      .o_frac(o_frac), .o_div(o_div)
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;

   // Behavioural model: mode 0 idle, 1 clear, 2 warm, 3 run
   int     m_state;
   int     warm_left;
   longint m_acc  [1:4];
   longint prev   [1:4];
   int     m_c    [1:4][0:3];
   int     newc   [1:4];
   longint mF;
   int     m_ord;
   int     m_lfsr;
   int     exp_frac, exp_div, exp_ack;
   int     y, nst, new_ord, fb;
   longint s;
   bit     chg;

   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         m_state = 0; warm_left = 0; mF = 0; m_ord = 1; m_lfsr = 16'hACE1;
         exp_frac = 0; exp_div = 0; exp_ack = 0;
         for (int k = 1; k <= 4; k++) begin
            m_acc[k] = 0;
            for (int d = 0; d < 4; d++) m_c[k][d] = 0;
         end
      end else begin
         y = 0;
         if (m_state >= 2)
            y = m_c[1][3] + m_c[2][2] - m_c[2][3] + m_c[3][1] - 2*m_c[3][2] + m_c[3][3]
              + m_c[4][0] - 3*m_c[4][1] + 3*m_c[4][2] - m_c[4][3];
         exp_frac = y;
         exp_div  = (int'(i_int) + y) & 255;
         exp_ack  = int'(i_cfg_we);
         if (m_state >= 2) begin
            for (int k = 1; k <= 4; k++) prev[k] = m_acc[k];
            s = m_acc[1] + mF + longint'(i_dither_en ? (m_lfsr & 1) : 0)
              + ((i_phase_we && m_state == 3) ? longint'(i_phase) : 64'sd0);
            newc[1] = (s >= MOD) ? 1 : 0;
            m_acc[1] = s % MOD;
            for (int k = 2; k <= 4; k++) begin
               s = prev[k] + prev[k-1];
               newc[k] = (s >= MOD && k <= m_ord) ? 1 : 0;
               m_acc[k] = s % MOD;
            end
            for (int k = 1; k <= 4; k++) begin
               for (int d = 3; d >= 1; d--) m_c[k][d] = m_c[k][d-1];
               m_c[k][0] = newc[k];
            end
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
         end else begin
            for (int k = 1; k <= 4; k++) begin
               m_acc[k] = 0;
               for (int d = 0; d < 4; d++) m_c[k][d] = 0;
            end
            if (m_state == 1) m_lfsr = (i_seed == 16'h0) ? 16'hACE1 : int'(i_seed);
         end
         new_ord = int'(i_cfg_order) + 1;
         if (new_ord > ORDER_MAX) new_ord = ORDER_MAX;
         chg = i_cfg_we && (new_ord != m_ord) && (m_state >= 2);
         nst = m_state;
         if (!i_en) nst = 0;
         else begin
            case (m_state)
               0: nst = 1;
               1: begin nst = 2; warm_left = ORDER_MAX + 1; end
               2: if (chg) nst = 1;
                  else begin
                     warm_left = warm_left - 1;
                     nst = (warm_left == 0) ? 3 : 2;
                  end
               default: nst = chg ? 1 : 3;
            endcase
         end
         m_state = nst;
         if (i_cfg_we) begin
            mF = longint'(i_cfg_frac);
            m_ord = new_ord;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic checkOutput();
      chk("valid", int'(o_valid), (m_state == 3) ? 1 : 0);
      chk("cfg_ack", int'(o_cfg_ack), exp_ack);
      if (m_state == 3) begin
         chk("frac", int'(o_frac), exp_frac);
         chk("div", int'(o_div), exp_div);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
      checkOutput();
      #1;
   endtask

   task automatic applyStimulus(input logic [ACC_W-1:0] f, input logic [1:0] ord);
      i_cfg_frac  = f;
      i_cfg_order = ord;
      i_cfg_we    = 1'b1;
      step();
      i_cfg_we    = 1'b0;
      chk("ack_pulse", int'(o_cfg_ack), 1);
   endtask

   task automatic wait_run();
      for (int i = 0; i < 20; i++) begin
         if (o_valid) break;
         step();
      end
      chk("wait_run", int'(o_valid), 1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   int f, sum, bad, alt_bad, prv, low, ones, mism, r;
   int rec [64];
   logic [ACC_W-1:0] f6;

   initial begin
      i_rst = 1'b1; i_en = 0; i_cfg_we = 0; i_cfg_frac = '0; i_cfg_order = '0;
      i_int = '0; i_phase_we = 0; i_phase = '0; i_dither_en = 0; i_seed = 16'h1234;
      step(); step();
      chk("rst_frac", int'(o_frac), 0);
      chk("rst_div", int'(o_div), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_ack", int'(o_cfg_ack), 0);
      i_rst = 1'b0;
      step();

      // F=0, order 3: output stays at the integer word
      i_int = 8'd40;
      applyStimulus('0, 2'd2);
      step();
      chk("idle_div", int'(o_div), 40);
      i_en = 1;
      low = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (o_valid) break;
         low++;
      end
      chk("warm_len", low, 6);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (o_frac != 0 || o_div != 8'd40) bad++;
         step();
      end
      chk("t1_const", bad, 0);

      // F=1/2, order 1: strict 0/1 alternation
      i_en = 0; step();
      i_int = 8'd10;
      applyStimulus(24'h800000, 2'd0);
      i_en = 1;
      wait_run();
      sum = 0; alt_bad = 0; bad = 0; prv = -1;
      for (int i = 0; i < 1024; i++) begin
         f = int'(o_frac);
         sum += f;
         if (f < 0 || f > 1 || int'(o_div) != 10 + f) bad++;
         if (prv >= 0 && f == prv) alt_bad++;
         prv = f;
         step();
      end
      chk("t2_sum", sum, 512);
      chk("t2_alt", alt_bad, 0);
      chk("t2_vals", bad, 0);

      // F=1/4, order 3: range, mean and divider wrap
      i_en = 0; step();
      i_int = 8'd0;
      applyStimulus(24'h400000, 2'd2);
      i_en = 1;
      wait_run();
      sum = 0; bad = 0;
      for (int i = 0; i < 4096; i++) begin
         f = int'(o_frac);
         sum += f;
         if (f < -3 || f > 4) bad++;
         if (f == -1) chk("t3_wrap", int'(o_div), 255);
         step();
      end
      chk("t3_range", bad, 0);
      chk_range("t3_mean", sum, 1020, 1028);

      // order 3 -> 2 while running forces a fresh warm-up
      i_cfg_frac = 24'h400000; i_cfg_order = 2'd1; i_cfg_we = 1;
      step();
      i_cfg_we = 0;
      chk("t4_ack", int'(o_cfg_ack), 1);
      low = 0;
      for (int i = 0; i < 20; i++) begin
         if (o_valid) break;
         low++;
         step();
      end
      chk("t4_low", low, 6);
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         if (o_frac < -1 || o_frac > 2) bad++;
         step();
      end
      chk("t4_range", bad, 0);

      // phase pulses: dropped in WARM, accumulated in RUN
      applyStimulus('0, 2'd0);
      step();
      i_phase = 24'hFFFFFF; i_phase_we = 1;
      step();
      i_phase_we = 0;
      wait_run();
      ones = 0;
      for (int i = 0; i < 20; i++) begin if (o_frac == 1) ones++; step(); end
      chk("t5_warm_pulse", ones, 0);
      i_phase_we = 1; step(); i_phase_we = 0;
      ones = 0;
      for (int i = 0; i < 20; i++) begin if (o_frac == 1) ones++; step(); end
      chk("t5_first", ones, 0);
      i_phase_we = 1; step(); i_phase_we = 0;
      ones = 0;
      for (int i = 0; i < 20; i++) begin if (o_frac == 1) ones++; step(); end
      chk("t5_second", ones, 1);

      // dithered run, async reset mid-run, identical replay with the same seed
      i_en = 0; step();
      f6 = 24'($urandom);
      i_seed = 16'($urandom);
      i_int = 8'd100;
      i_dither_en = 1;
      applyStimulus(f6, 2'd3);
      i_en = 1;
      wait_run();
      for (int i = 0; i < 64; i++) begin rec[i] = int'(o_frac); step(); end
      #1;
      i_rst = 1'b1;
      #1;
      chk("arst_frac", int'(o_frac), 0);
      chk("arst_div", int'(o_div), 0);
      chk("arst_valid", int'(o_valid), 0);
      chk("arst_ack", int'(o_cfg_ack), 0);
      step();
      i_rst = 1'b0; i_en = 0;
      step();
      applyStimulus(f6, 2'd3);
      i_en = 1;
      wait_run();
      mism = 0;
      for (int i = 0; i < 64; i++) begin
         if (int'(o_frac) != rec[i]) mism++;
         step();
      end
      chk("t6_replay", mism, 0);

      // randomized operation against the model
      for (int it = 0; it < 6; it++) begin
         i_en = 0; step();
         i_int = 8'($urandom);
         i_dither_en = 1'($urandom_range(0, 1));
         i_seed = 16'($urandom);
         applyStimulus(24'($urandom), 2'($urandom_range(0, 3)));
         i_en = 1;
         for (int c = 0; c < 300; c++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
               i_phase_we = 1; i_phase = 24'($urandom);
            end else if (r == 4) begin
               i_cfg_we = 1; i_cfg_frac = 24'($urandom); i_cfg_order = 2'($urandom_range(0, 3));
            end else if (r == 5) begin
               i_en = 0;
            end
            step();
            i_phase_we = 0; i_cfg_we = 0; i_en = 1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
